// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive engines.
//   tx_state_t : transmit FSM state encoding (IDLE, SEND)
//   START_BIT  : line level of the start bit
//   STOP_BIT   : line level of the stop bit (also the idle level)
//   frame_len  : total bits on the wire for a frame, start to stop
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // 1 start + 7 or 8 data + optional parity + 1 stop -> 9..11 bits.
  function automatic logic [3:0] frame_len(input logic eight, input logic pen);
    frame_len = 4'd9 + {3'b000, eight} + {3'b000, pen};
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Bit-time counter shared by the UART engines. Counts 0..k-1 while enabled,
// where k = max(i_k, 1), and pulses o_bit_done during the final count.
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   i_clear    restart the count at 0 on the next edge
//   i_en       count enable
//   i_k        clocks per bit (0 is treated as 1)
//   o_bit_done one-cycle pulse on the last clock of a bit
// ---------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [BAUD_W-1:0] i_k,
  output logic              o_bit_done
);

  logic [BAUD_W-1:0] r_count;
  logic [BAUD_W-1:0] w_last;

  // A zero bit time collapses to one clock per bit.
  assign w_last     = (i_k == '0) ? '0 : i_k - {{(BAUD_W-1){1'b0}}, 1'b1};
  assign o_bit_done = i_en && (r_count == w_last);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_bit_done ? '0 : r_count + {{(BAUD_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// Serialises one byte per load strobe as an asynchronous UART frame
// (start, 7/8 data LSB first, optional parity, one stop). Frame options and
// bit time are captured at load; later input changes do not affect a frame
// already in flight.
// Build option: define UART_TX_BREAK_EN to add break_req (hold the line low
// while idle).
// Ports:
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset
//   load      one-cycle write strobe, accepted only while idle
//   out_port  byte to transmit
//   baud_k    clocks per bit (0 is treated as 1)
//   eight     1 = 8 data bits, 0 = 7 data bits
//   pen       parity enable
//   ohel      parity sense, 0 = even, 1 = odd
//   break_req (UART_TX_BREAK_EN only) force a break while idle
//   tx        registered serial line, idle high
//   txrdy     1 = idle and ready for load
// ---------------------------------------------------------------------------
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] out_port,
  input  logic [BAUD_W-1:0] baud_k,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
`ifdef UART_TX_BREAK_EN
  input  logic              break_req,
`endif
  output logic              tx,
  output logic              txrdy
);

  // Bits that follow the start bit: up to DATA_W data, parity, stop.
  localparam int FW = DATA_W + 2;

  tx_state_t         r_state, w_state_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_txrdy, w_txrdy_nxt;
  logic [FW-1:0]     r_shift, w_shift_nxt;
  logic [3:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]        r_len, w_len_nxt;
  logic [BAUD_W-1:0] r_k, w_k_nxt;

  logic              w_timer_clr;
  logic              w_timer_en;
  logic              w_bit_done;
  logic              w_break;
  logic              w_parity;
  logic [DATA_W-1:0] w_data_bits;
  logic [FW-1:0]     w_frame;

`ifdef UART_TX_BREAK_EN
  assign w_break = break_req;
`else
  assign w_break = 1'b0;
`endif

  assign tx    = r_tx;
  assign txrdy = r_txrdy;

  // Bit 7 is excluded from parity when only seven bits go out.
  assign w_data_bits = eight ? out_port : {1'b0, out_port[DATA_W-2:0]};
  assign w_parity    = (^w_data_bits) ^ ohel;

  // Frame image after the start bit, LSB first. Unused upper positions are
  // filled with ones, which equals STOP_BIT, so the stop bit lands wherever
  // the data/parity field ends.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_frame = '1;
    if (eight) begin
      w_frame[DATA_W-1:0] = out_port;
      w_frame[DATA_W]     = pen ? w_parity : STOP_BIT;
    end else begin
      w_frame[DATA_W-2:0] = out_port[DATA_W-2:0];
      w_frame[DATA_W-1]   = pen ? w_parity : STOP_BIT;
    end
  end

  assign w_timer_en = (r_state == ST_SEND);

  uart_bit_timer #(
    .BAUD_W (BAUD_W)
  ) u_bit_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_timer_clr),
    .i_en       (w_timer_en),
    .i_k        (r_k),
    .o_bit_done (w_bit_done)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_txrdy_nxt   = r_txrdy;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_len_nxt     = r_len;
    w_k_nxt       = r_k;
    w_timer_clr   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_break) begin
          w_tx_nxt    = START_BIT;
          w_txrdy_nxt = 1'b0;
        end else if (load) begin
          w_state_nxt   = ST_SEND;
          w_shift_nxt   = w_frame;
          w_bit_cnt_nxt = '0;
          w_len_nxt     = frame_len(eight, pen);
          w_k_nxt       = baud_k;
          w_timer_clr   = 1'b1;
          w_tx_nxt      = START_BIT;
          w_txrdy_nxt   = 1'b0;
        end else begin
          w_tx_nxt    = STOP_BIT;
          w_txrdy_nxt = 1'b1;
        end
      end

      ST_SEND: begin
        if (w_bit_done) begin
          if (r_bit_cnt == r_len - 4'd1) begin
            // End of the stop bit: line is already high, just go idle.
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = STOP_BIT;
            w_txrdy_nxt = 1'b1;
          end else begin
            w_tx_nxt      = r_shift[0];
            w_shift_nxt   = {1'b1, r_shift[FW-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= STOP_BIT;
      r_txrdy   <= 1'b1;
      r_shift   <= '1;
      r_bit_cnt <= '0;
      r_len     <= '0;
      r_k       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_txrdy   <= w_txrdy_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_len     <= w_len_nxt;
      r_k       <= w_k_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
// Directed bench for uart_tx_engine. Inputs change and outputs are sampled
// on the falling edge. Each vector holds the expected wire sequence
// (LSB = start bit) and frame length, both worked out by hand.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [7:0]  out_port;
  logic [19:0] baud_k;
  logic        eight;
  logic        pen;
  logic        ohel;
`ifdef UART_TX_BREAK_EN
  logic        break_req = 1'b0;
`endif
  logic        tx;
  logic        txrdy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_W(8), .BAUD_W(20)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .out_port (out_port),
    .baud_k   (baud_k),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx       (tx),
    .txrdy    (txrdy)
  );

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic [19:0] baud;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [10:0] seq;   // expected wire bits, bit 0 = start bit
    int          n;     // frame length in bits
    int          k;     // effective clocks per bit
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called on a falling edge; pulses load for one cycle and returns on the
  // falling edge of the first frame cycle.
  task automatic start_frame(input vec_t v);
    out_port = v.data;
    baud_k   = v.baud;
    eight    = v.eight;
    pen      = v.pen;
    ohel     = v.ohel;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Follows a frame cycle by cycle until txrdy rises (bounded). Optionally
  // injects a load (plus option changes) at cycle busy_at. Returns on the
  // falling edge where txrdy was first seen high.
  task automatic run_frame(input vec_t v, input int busy_at, input logic [7:0] busy_data);
    int cnt = 0;
    while (txrdy == 1'b0 && cnt < 400) begin
      if (cnt < v.n * v.k) check({v.name, " tx"}, {31'd0, tx}, {31'd0, v.seq[cnt / v.k]});
      if (cnt == busy_at) begin
        load     = 1'b1;
        out_port = busy_data;
        baud_k   = 20'd7;
        eight    = 1'b0;
        pen      = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    load = 1'b0;
    check({v.name, " txrdy low cycles"}, cnt, v.n * v.k);
    check({v.name, " tx idle"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    //        name        data   baud   8  p  o  seq       n   k
    vecs[0] = '{"0x55 k4",  8'h55, 20'd4, 1, 0, 0, 11'h2AA, 10, 4};
    vecs[1] = '{"0x03 even", 8'h03, 20'd2, 1, 1, 0, 11'h406, 11, 2};
    vecs[2] = '{"0x03 odd", 8'h03, 20'd2, 1, 1, 1, 11'h606, 11, 2};
    vecs[3] = '{"0xFF 7bit", 8'hFF, 20'd3, 0, 0, 0, 11'h1FE, 9, 3};
    vecs[4] = '{"0x0F k0",  8'h0F, 20'd0, 1, 0, 0, 11'h21E, 10, 1};
    vecs[5] = '{"0x81 7b p", 8'h81, 20'd2, 0, 1, 0, 11'h302, 10, 2};
    vecs[6] = '{"0xA5 odd", 8'hA5, 20'd2, 1, 1, 1, 11'h74A, 11, 2};

    reset_n  = 1'b0;
    load     = 1'b0;
    out_port = 8'h00;
    baud_k   = 20'd4;
    eight    = 1'b1;
    pen      = 1'b0;
    ohel     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset txrdy", {31'd0, txrdy}, 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      start_frame(vecs[i]);
      run_frame(vecs[i], -1, 8'h00);
      repeat (2) @(negedge clk);
    end

    // Busy load at cycle 10 (with option changes) must not disturb the frame;
    // the next frame is loaded on the txrdy-rise cycle with no idle bit.
    begin
      vec_t busy;
      busy = '{"busy 0xA5", 8'hA5, 20'd2, 1, 0, 0, 11'h34A, 10, 2};
      start_frame(busy);
      run_frame(busy, 10, 8'h00);
      start_frame(vecs[5]);
      run_frame(vecs[5], -1, 8'h00);
      for (int c = 0; c < 5; c++) begin
        check("post b2b idle tx", {31'd0, tx}, 32'd1);
        check("post b2b idle txrdy", {31'd0, txrdy}, 32'd1);
        @(negedge clk);
      end
    end

    // Reset during bit 4 of a k=4 frame, then a clean frame.
    start_frame(vecs[0]);
    repeat (16) @(negedge clk);
    check("pre-reset busy", {31'd0, txrdy}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid-frame reset tx", {31'd0, tx}, 32'd1);
    check("mid-frame reset txrdy", {31'd0, txrdy}, 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    check("after reset idle", {31'd0, txrdy}, 32'd1);
    start_frame(vecs[5]);
    run_frame(vecs[5], -1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Serial transmit engine downstream of the port address decoder. It is loaded by the decoder's one-hot write strobe (bit 0) with the processor's 8-bit out_port byte. It serializes the byte as an asynchronous UART frame on tx, paced by a programmable bit-time count. txrdy reports idle and is read back by the processor through the decoder's read path.

Parameters:
DATA_W, 8, width of out_port and the shift data field
BAUD_W, 20, width of baud_k bit-time count

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
load  input  1  one-cycle write strobe (decoder writes[0])
out_port  input  DATA_W  byte to transmit
baud_k  input  BAUD_W  clocks per bit
eight  input  1  1 = 8 data bits, 0 = 7 data bits (bit 7 not sent)
pen  input  1  parity enable
ohel  input  1  parity sense: 0 = even, 1 = odd
tx  output  1  serial line, idle high
txrdy  output  1  1 = idle, ready for load

Behaviour:
- Single clock domain; reset is synchronous and active-low on reset_n.
- Reset: tx=1, txrdy=1, state IDLE, all counters 0.
- Reset asserted mid-frame: on the next edge tx=1, txrdy=1, frame abandoned.
- Effective bit time: k = max(baud_k, 1) clocks per bit.
- Capture on load: baud_k, eight, pen, and ohel are captured with the data. Changes to them mid-frame have no effect.
- States: IDLE, SEND.
- IDLE→SEND: load=1 in IDLE.
  - Same edge: latch the frame into the shift register and clear the bit and bit-time counters.
  - Same edge: txrdy←0 and tx←0 (start bit).
  - Visible the cycle after the load edge.
- Frame is sent LSB first:
  - start bit (0);
  - 7 or 8 data bits;
  - parity bit if pen=1;
  - one stop bit (1).
- Frame length: N = 1 + (eight ? 8 : 7) + pen + 1, so 9 to 11 bits.
- Parity: XOR of the transmitted data bits, XORed with ohel. Even parity gives an even count of 1s over data plus parity.
- Bit advance: the bit-time counter counts 0..k-1. At k-1 it wraps, the shift register shifts right, and the bit counter increments.
- SEND→IDLE: on the edge ending the stop bit (bit counter = N-1, bit-time = k-1).
  - tx stays 1 and txrdy←1 on that edge.
  - txrdy is therefore low for exactly N·k cycles.
- Load while busy: load=1 while txrdy=0 is ignored. The byte is dropped and the frame in flight is undisturbed.
- Load on the txrdy-rising cycle: load=1 on the first IDLE cycle is accepted (back-to-back frames, no gap).
- tx is registered, with no combinational path from inputs to tx.

Optional Feature:
Macro: UART_TX_BREAK_EN
- Defined: adds input port break_req.
  - While break_req=1 in IDLE, tx is forced to 0 and txrdy=0.
  - load is ignored during break.
  - On release, tx returns to 1 and txrdy returns to 1 on the next edge.
  - break_req during SEND takes effect after the frame completes.
- Not defined: port absent, behaviour as above.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (IDLE, SEND);
  - START_BIT=0 and STOP_BIT=1;
  - the frame-length function of eight/pen.
- One sub-module, uart_bit_timer:
  - loadable BAUD_W counter with a clear input;
  - emits a one-cycle bit_done pulse at k-1.
- The receive engine reuses uart_bit_timer.

Test Plan:
- k=4, eight=1, pen=0, load 0x55:
  - tx = 0,1,0,1,0,1,0,1,0,1, each held 4 clocks;
  - txrdy low for exactly 40 cycles, then high.
- k=2, eight=1, pen=1, data 0x03:
  - ohel=0 gives parity bit 0;
  - ohel=1 gives parity bit 1;
  - txrdy low 22 cycles.
- k=3, eight=0, pen=0, load 0xFF:
  - 7 ones sent after start, stop follows immediately;
  - txrdy low 27 cycles.
- Busy load: load 0xA5, then load 0x00 at cycle 10:
  - only the 0xA5 frame appears;
  - a load on the txrdy-rise cycle starts a new frame with no idle bit.
- Reset mid-frame: reset_n=0 at bit 4 → next edge tx=1, txrdy=1; a subsequent load of 0x81 transmits correctly.
- baud_k=0: load 0x0F → one clock per bit, 10-cycle frame.
